sr_shift_send: RTL and testbench
================================

# sr_shift_send

Serial writer for the TMIIa configuration shift register. It accepts a DATA_WIDTH-bit word on a valid/ready handshake and generates `start` for the shift-register receive stage. It then shifts the word out one bit per clock while the receive stage captures the old contents, and finishes with a parallel-load pulse. It sits directly upstream of the receive stage and shares its `start`, clock and bit ordering.

## Interface
- `DATA_WIDTH`, 170: bits per shift-register frame.
- `CNT_WIDTH`, 8: bit counter width. The counter is CNT_WIDTH+1 bits and must hold DATA_WIDTH.
- `SHIFT_DIRECTION`, 1: 1 sends `din[DATA_WIDTH-1]` first (MSB first); 0 sends `din[0]` first.

Ports:
- `clk`  in  1: control clock. All state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `din`  in  DATA_WIDTH: word to write.
- `din_valid`  in  1: write request.
- `ready`  out  1: block idle; request accepted when `din_valid & ready`.
- `start`  out  1: one-cycle pulse to the receive stage.
- `sr_data`  out  1: serial data to the shift register.
- `sr_clk_en`  out  1: shift-register clock gate; high for exactly DATA_WIDTH cycles per frame.
- `sr_load`  out  1: one-cycle parallel-latch pulse after the last bit.
- `done`  out  1: one-cycle pulse when the frame completes.
- `rb_data`  in  DATA_WIDTH: readback word from the receive stage. Only present with the macro.
- `rb_valid`  in  1: readback strobe. Only present with the macro.
- `mismatch`  out  1: readback check result. Only present with the macro.

## Operation
- FSM states: IDLE, ARM, GAP, SHIFT, LOAD, DONE. All outputs are registered.
- **IDLE:** `ready`=1. On `din_valid`, latch `din` into the holding register, clear the counter and go to ARM. `din_valid` in any other state is ignored and the held word is unchanged.
- **ARM:** `start`=1 for one cycle, then go to GAP.
- **GAP:** one cycle with all outputs low. It aligns the first bit with the receive stage's two-cycle start-up. Go to SHIFT.
- **SHIFT:**
  - `sr_clk_en`=1.
  - `sr_data` = held bit at `DATA_WIDTH-1-cnt` when SHIFT_DIRECTION=1, or at `cnt` when 0.
  - `cnt` increments each cycle.
  - After the bit with `cnt==DATA_WIDTH-1`, go to LOAD.
- **LOAD:** `sr_load`=1, `sr_clk_en`=0, `sr_data`=0. Go to DONE.
- **DONE:** `done`=1 and `ready`=1 in the same cycle. A `din_valid` in this cycle is accepted, giving back-to-back frames.
- **Otherwise:** DONE returns to IDLE.
- **Illegal states:** any illegal state encoding recovers to IDLE on the next clock.

## Timing
- Reset values: `ready`=1, `start`=0, `sr_data`=0, `sr_clk_en`=0, `sr_load`=0, `done`=0, `mismatch`=0. The counter and holding register clear.
- Reset assertion mid-frame drops all outputs to their reset values immediately (asynchronous). No partial `sr_load` is issued.
- Cycle numbering: acceptance edge = cycle 0. Then:
  - `start` high in cycle 1.
  - GAP in cycle 2.
  - bit i on `sr_data` in cycle 3+i, for i = 0..DATA_WIDTH-1.
  - `sr_load` in cycle DATA_WIDTH+3.
  - `done`/`ready` in cycle DATA_WIDTH+4.
- Frame period: DATA_WIDTH+4 cycles back-to-back, i.e. 174 for the default width.
- `sr_data` is stable for the full cycle, so the receive stage's falling-edge sample lands mid-bit.

## Configuration
- Macro: `SR_SHIFT_SEND_READBACK_CHECK_EN`.
- **Defined:**
  - Adds `rb_data`, `rb_valid` and `mismatch`.
  - On each `done`, the held word is copied to a reference register and a `ref_ok` flag sets.
  - On `rb_valid` with `ref_ok`=1: `mismatch` <= (`rb_data != reference`), registered next cycle. It holds until the next `rb_valid`.
  - On `rb_valid` with `ref_ok`=0 (first frame after reset), `mismatch` stays 0.
  - If `rb_valid` and `done` occur in the same cycle, the compare uses the old reference, then the reference updates.
- **Undefined:** the ports and logic are absent, and the FSM behaviour is identical.

## Test plan
- **Single frame, default parameters.** Reset, then `din`=170'h2_AAAA…AAAA with `din_valid` for 1 cycle.
  - `start` in cycle 1.
  - 170 `sr_data` bits from cycle 3, `din[169]` first, alternating 1/0.
  - `sr_clk_en` high for exactly 170 cycles.
  - `sr_load` in cycle 173, `done` in cycle 174.
- **SHIFT_DIRECTION=0, DATA_WIDTH=8.** `din`=8'h01 → `sr_data`=1 in cycle 3 only, `done` in cycle 12.
- **Back-to-back.** `din_valid` held high with 8'hF0 then 8'h0F (DATA_WIDTH=8) → second `start` in the cycle after the first `done`; period 12 cycles; no gap cycles.
- **Ignored request.** `din_valid` pulsed with 8'hFF during SHIFT of 8'h00 → all shifted bits are 0; no extra frame follows.
- **Reset mid-SHIFT.** Assert `rst` low at bit 50 → `sr_clk_en`, `sr_data` and `start` drop to 0 immediately; no `sr_load`; `ready`=1 after release.
- **Readback (macro defined).**
  - Write A=170'h1, then B=170'h2.
  - `rb_valid` with `rb_data`=170'h1 after the second frame → `mismatch`=0.
  - Repeat with `rb_data`=170'h3 → `mismatch`=1.
  - `rb_valid` before any write → `mismatch`=0.

Source files
------------

// File: rtl/sr_shift_send_if.sv
// sr_shift_send_if: handshake and shift-register bus for sr_shift_send.
//   slave  modport (writer side): din/din_valid in; ready, start, sr_data, sr_clk_en,
//                                 sr_load, done out.
//   master modport (producer side): mirror of the slave.
// Optional readback group (rb_data, rb_valid in; mismatch out) exists only when
// SR_SHIFT_SEND_READBACK_CHECK_EN is defined.
interface sr_shift_send_if #(
    parameter int unsigned DATA_WIDTH = 170
);
    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic                  ready;
    logic                  start;
    logic                  sr_data;
    logic                  sr_clk_en;
    logic                  sr_load;
    logic                  done;
`ifdef SR_SHIFT_SEND_READBACK_CHECK_EN
    logic [DATA_WIDTH-1:0] rb_data;
    logic                  rb_valid;
    logic                  mismatch;

    modport master (
        output din, din_valid, rb_data, rb_valid,
        input  ready, start, sr_data, sr_clk_en, sr_load, done, mismatch
    );
    modport slave (
        input  din, din_valid, rb_data, rb_valid,
        output ready, start, sr_data, sr_clk_en, sr_load, done, mismatch
    );
`else
    modport master (
        output din, din_valid,
        input  ready, start, sr_data, sr_clk_en, sr_load, done
    );
    modport slave (
        input  din, din_valid,
        output ready, start, sr_data, sr_clk_en, sr_load, done
    );
`endif
endinterface

// File: rtl/sr_shift_send.sv
// sr_shift_send: serial writer for the TMIIa configuration shift register.
// Accepts a DATA_WIDTH-bit word on din/din_valid/ready, pulses start for the receive
// stage, waits one gap cycle, shifts the word out one bit per clock with sr_clk_en high,
// then pulses sr_load and done. All outputs are registered.
// Ports:
//   clk  - control clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - sr_shift_send_if.slave (din, din_valid, ready, start, sr_data, sr_clk_en,
//          sr_load, done; plus rb_data, rb_valid, mismatch with the macro)
// Optional feature macro: SR_SHIFT_SEND_READBACK_CHECK_EN (readback compare).
module sr_shift_send #(
    parameter int unsigned DATA_WIDTH      = 170,
    parameter int unsigned CNT_WIDTH       = 8,
    parameter int unsigned SHIFT_DIRECTION = 1
) (
    input logic            clk,
    input logic            rst,
    sr_shift_send_if.slave bus
);
    localparam int unsigned        IdxW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_WIDTH:0] LastCnt = (CNT_WIDTH + 1)'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArm   = 3'd1,
        StGap   = 3'd2,
        StShift = 3'd3,
        StLoad  = 3'd4,
        StDone  = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  ready_q, ready_d;
    logic                  start_q, start_d;
    logic                  sr_data_q, sr_data_d;
    logic                  sr_clk_en_q, sr_clk_en_d;
    logic                  sr_load_q, sr_load_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic [IdxW-1:0]       bit_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        accept  = bus.din_valid && ((state_q == StIdle) || (state_q == StDone));

        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = StArm;
                    hold_d  = bus.din;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StArm:   state_d = StGap;
            StGap:   state_d = StShift;
            StShift: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StLoad;
                end
            end
            StLoad:  state_d = StDone;
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so the registered value lines up with
        // the state it belongs to; cnt_d is the index of the bit driven next cycle.
        if (SHIFT_DIRECTION != 0) begin
            bit_idx = IdxW'(LastCnt - cnt_d);
        end else begin
            bit_idx = IdxW'(cnt_d);
        end
        ready_d     = (state_d == StIdle) || (state_d == StDone);
        start_d     = (state_d == StArm);
        sr_clk_en_d = (state_d == StShift);
        sr_data_d   = (state_d == StShift) && hold_d[bit_idx];
        sr_load_d   = (state_d == StLoad);
        done_d      = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hold_q      <= '0;
            ready_q     <= 1'b1;
            start_q     <= 1'b0;
            sr_data_q   <= 1'b0;
            sr_clk_en_q <= 1'b0;
            sr_load_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            ready_q     <= ready_d;
            start_q     <= start_d;
            sr_data_q   <= sr_data_d;
            sr_clk_en_q <= sr_clk_en_d;
            sr_load_q   <= sr_load_d;
            done_q      <= done_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.start     = start_q;
    assign bus.sr_data   = sr_data_q;
    assign bus.sr_clk_en = sr_clk_en_q;
    assign bus.sr_load   = sr_load_q;
    assign bus.done      = done_q;

`ifdef SR_SHIFT_SEND_READBACK_CHECK_EN
    logic [DATA_WIDTH-1:0] ref_word_q, ref_word_d;
    logic                  ref_ok_q, ref_ok_d;
    logic                  mismatch_q, mismatch_d;

    // Compare reads the current reference; a coincident done only updates it afterwards.
    always_comb begin
        ref_word_d = ref_word_q;
        ref_ok_d   = ref_ok_q;
        mismatch_d = mismatch_q;
        if (bus.rb_valid && ref_ok_q) begin
            mismatch_d = (bus.rb_data != ref_word_q);
        end
        if (done_q) begin
            ref_word_d = hold_q;
            ref_ok_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_word_q <= '0;
            ref_ok_q   <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            ref_word_q <= ref_word_d;
            ref_ok_q   <= ref_ok_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.mismatch = mismatch_q;
`endif
endmodule

// File: tb/tb_sr_shift_send.sv
// tb_sr_shift_send: self-checking bench for sr_shift_send.
// DUT A: DATA_WIDTH=170, MSB first. DUT B: DATA_WIDTH=8, LSB first.
// Expected serial bits are queued when a word is written and popped per shift cycle.
// Readback scenario is compiled only with SR_SHIFT_SEND_READBACK_CHECK_EN.
module tb_sr_shift_send;
    localparam int unsigned WA = 170;
    localparam int unsigned WB = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sr_shift_send_if #(.DATA_WIDTH(WA)) bus_a ();
    sr_shift_send_if #(.DATA_WIDTH(WB)) bus_b ();

    sr_shift_send #(.DATA_WIDTH(WA), .CNT_WIDTH(8), .SHIFT_DIRECTION(1)) u_dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a.slave)
    );

    sr_shift_send #(.DATA_WIDTH(WB), .CNT_WIDTH(4), .SHIFT_DIRECTION(0)) u_dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b.slave)
    );

    // {ready, start, sr_clk_en, sr_data, sr_load, done}
    logic [5:0] obs_a;
    logic [5:0] obs_b;
    assign obs_a = {bus_a.ready, bus_a.start, bus_a.sr_clk_en, bus_a.sr_data, bus_a.sr_load,
                    bus_a.done};
    assign obs_b = {bus_b.ready, bus_b.start, bus_b.sr_clk_en, bus_b.sr_data, bus_b.sr_load,
                    bus_b.done};

    int   n_cmp = 0;
    int   n_bad = 0;
    logic sb_a[$];
    logic sb_b[$];

    // Expected outputs in frame cycle p (1 = start cycle); p = 0 means idle.
    function automatic logic [5:0] exp_out(input int p, input int w, input logic b);
        logic [5:0] e;
        e = 6'b000000;
        if (p == 0) e[5] = 1'b1;
        if (p == 1) e[4] = 1'b1;
        if (p >= 3 && p <= w + 2) begin
            e[3] = 1'b1;
            e[2] = b;
        end
        if (p == w + 3) e[1] = 1'b1;
        if (p == w + 4) begin
            e[5] = 1'b1;
            e[0] = 1'b1;
        end
        return e;
    endfunction

    task automatic push_a(input logic [WA-1:0] w);
        for (int i = WA - 1; i >= 0; i--) sb_a.push_back(w[i]);
    endtask

    task automatic push_b(input logic [WB-1:0] w);
        for (int i = 0; i < WB; i++) sb_b.push_back(w[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (obs_a !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_a: got %b want %b", obs_a, 6'b100000);
        end
        n_cmp++;
        if (obs_b !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_b: got %b want %b", obs_b, 6'b100000);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (obs_a !== 6'b100000) begin
            n_bad++;
            $display("FAIL post_reset_a: got %b want %b", obs_a, 6'b100000);
        end
        n_cmp++;
        if (obs_b !== 6'b100000) begin
            n_bad++;
            $display("FAIL post_reset_b: got %b want %b", obs_b, 6'b100000);
        end
    endtask

    task automatic test_single_frame();
        logic [WA-1:0] w;
        logic [5:0]    exp_v;
        int            en_cnt;
        w      = {85{2'b10}};
        en_cnt = 0;
        push_a(w);
        bus_a.din       = w;
        bus_a.din_valid = 1'b1;
        tick();
        bus_a.din_valid = 1'b0;
        for (int p = 1; p <= WA + 6; p++) begin
            int   q;
            logic b;
            q = (p <= WA + 4) ? p : 0;
            b = 1'b0;
            if (q >= 3 && q <= WA + 2) begin
                if (sb_a.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL single_frame_sb: queue empty at cycle %0d", p);
                end else begin
                    b = sb_a.pop_front();
                end
            end
            exp_v = exp_out(q, WA, b);
            n_cmp++;
            if (obs_a !== exp_v) begin
                n_bad++;
                $display("FAIL single_frame cycle %0d: got %b want %b", p, obs_a, exp_v);
            end
            if (bus_a.sr_clk_en === 1'b1) en_cnt++;
            tick();
        end
        n_cmp++;
        if (en_cnt != WA) begin
            n_bad++;
            $display("FAIL single_frame_clk_en_count: got %0d want %0d", en_cnt, WA);
        end
    endtask

    task automatic test_lsb_first();
        logic [5:0] exp_v;
        push_b(8'h01);
        bus_b.din       = 8'h01;
        bus_b.din_valid = 1'b1;
        tick();
        bus_b.din_valid = 1'b0;
        for (int p = 1; p <= WB + 6; p++) begin
            int   q;
            logic b;
            q = (p <= WB + 4) ? p : 0;
            b = 1'b0;
            if (q >= 3 && q <= WB + 2 && sb_b.size() != 0) b = sb_b.pop_front();
            exp_v = exp_out(q, WB, b);
            n_cmp++;
            if (obs_b !== exp_v) begin
                n_bad++;
                $display("FAIL lsb_first cycle %0d: got %b want %b", p, obs_b, exp_v);
            end
            tick();
        end
        n_cmp++;
        if (sb_b.size() != 0) begin
            n_bad++;
            $display("FAIL lsb_first_sb: %0d bits left want 0", sb_b.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_v;
        push_b(8'hF0);
        push_b(8'h0F);
        bus_b.din       = 8'hF0;
        bus_b.din_valid = 1'b1;
        tick();
        bus_b.din = 8'h0F;
        for (int p = 1; p <= 2 * (WB + 4) + 3; p++) begin
            int   q;
            logic b;
            q = (p <= 2 * (WB + 4)) ? ((p - 1) % (WB + 4)) + 1 : 0;
            b = 1'b0;
            if (q >= 3 && q <= WB + 2 && sb_b.size() != 0) b = sb_b.pop_front();
            exp_v = exp_out(q, WB, b);
            n_cmp++;
            if (obs_b !== exp_v) begin
                n_bad++;
                $display("FAIL back_to_back cycle %0d: got %b want %b", p, obs_b, exp_v);
            end
            tick();
            if (p == WB + 4) bus_b.din_valid = 1'b0;
        end
        n_cmp++;
        if (sb_b.size() != 0) begin
            n_bad++;
            $display("FAIL back_to_back_sb: %0d bits left want 0", sb_b.size());
        end
    endtask

    task automatic test_ignored_request();
        logic [5:0] exp_v;
        push_b(8'h00);
        bus_b.din       = 8'h00;
        bus_b.din_valid = 1'b1;
        tick();
        bus_b.din_valid = 1'b0;
        for (int p = 1; p <= WB + 8; p++) begin
            int   q;
            logic b;
            q = (p <= WB + 4) ? p : 0;
            b = 1'b0;
            if (q >= 3 && q <= WB + 2 && sb_b.size() != 0) b = sb_b.pop_front();
            exp_v = exp_out(q, WB, b);
            n_cmp++;
            if (obs_b !== exp_v) begin
                n_bad++;
                $display("FAIL ignored_request cycle %0d: got %b want %b", p, obs_b, exp_v);
            end
            if (p == 5) begin
                bus_b.din       = 8'hFF;
                bus_b.din_valid = 1'b1;
            end
            tick();
            if (p == 5) bus_b.din_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [WA-1:0] w;
        logic [5:0]    seen_or;
        logic          seen_bad;
        w = '1;
        bus_a.din       = w;
        bus_a.din_valid = 1'b1;
        tick();
        bus_a.din_valid = 1'b0;
        repeat (52) tick();
        n_cmp++;
        if (obs_a !== 6'b001100) begin
            n_bad++;
            $display("FAIL mid_shift_bit50: got %b want %b", obs_a, 6'b001100);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (obs_a !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_async_drop: got %b want %b", obs_a, 6'b100000);
        end
        repeat (2) tick();
        rst      = 1'b1;
        seen_or  = 6'b000000;
        seen_bad = 1'b0;
        for (int p = 0; p < 200; p++) begin
            tick();
            seen_or = seen_or | obs_a;
            if (obs_a !== 6'b100000) seen_bad = 1'b1;
        end
        n_cmp++;
        if (seen_or[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_load: got sr_load seen=%b want 0", seen_or[1]);
        end
        n_cmp++;
        if (seen_bad !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_after: got outputs-or %b want 100000", seen_or);
        end
    endtask

`ifdef SR_SHIFT_SEND_READBACK_CHECK_EN
    task automatic wait_done_a(input string tag);
        for (int k = 0; k < 400 && bus_a.done !== 1'b1; k++) tick();
        n_cmp++;
        if (bus_a.done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done_timeout: got done=%b want 1", tag, bus_a.done);
        end
    endtask

    task automatic test_readback();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        bus_a.rb_data  = WA'(5);
        bus_a.rb_valid = 1'b1;
        tick();
        bus_a.rb_valid = 1'b0;
        n_cmp++;
        if (bus_a.mismatch !== 1'b0) begin
            n_bad++;
            $display("FAIL rb_before_write: got %b want 0", bus_a.mismatch);
        end
        // Frame A, then B accepted in A's done cycle.
        bus_a.din       = WA'(1);
        bus_a.din_valid = 1'b1;
        tick();
        bus_a.din_valid = 1'b0;
        wait_done_a("rb_frame_a");
        bus_a.din       = WA'(2);
        bus_a.din_valid = 1'b1;
        tick();
        bus_a.din_valid = 1'b0;
        wait_done_a("rb_frame_b");
        // Readback coincident with B's done compares against A; B is rewritten.
        bus_a.rb_data   = WA'(1);
        bus_a.rb_valid  = 1'b1;
        bus_a.din       = WA'(2);
        bus_a.din_valid = 1'b1;
        tick();
        bus_a.rb_valid  = 1'b0;
        bus_a.din_valid = 1'b0;
        n_cmp++;
        if (bus_a.mismatch !== 1'b0) begin
            n_bad++;
            $display("FAIL rb_match_old_ref: got %b want 0", bus_a.mismatch);
        end
        wait_done_a("rb_frame_b2");
        bus_a.rb_data  = WA'(3);
        bus_a.rb_valid = 1'b1;
        tick();
        bus_a.rb_valid = 1'b0;
        n_cmp++;
        if (bus_a.mismatch !== 1'b1) begin
            n_bad++;
            $display("FAIL rb_mismatch: got %b want 1", bus_a.mismatch);
        end
        repeat (3) tick();
        n_cmp++;
        if (bus_a.mismatch !== 1'b1) begin
            n_bad++;
            $display("FAIL rb_mismatch_hold: got %b want 1", bus_a.mismatch);
        end
        bus_a.rb_data  = WA'(2);
        bus_a.rb_valid = 1'b1;
        tick();
        bus_a.rb_valid = 1'b0;
        n_cmp++;
        if (bus_a.mismatch !== 1'b0) begin
            n_bad++;
            $display("FAIL rb_match_new_ref: got %b want 0", bus_a.mismatch);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.din       = '0;
        bus_a.din_valid = 1'b0;
        bus_b.din       = '0;
        bus_b.din_valid = 1'b0;
`ifdef SR_SHIFT_SEND_READBACK_CHECK_EN
        bus_a.rb_data  = '0;
        bus_a.rb_valid = 1'b0;
        bus_b.rb_data  = '0;
        bus_b.rb_valid = 1'b0;
`endif
        test_reset();
        test_single_frame();
        test_lsb_first();
        test_back_to_back();
        test_ignored_request();
        test_reset_mid_shift();
`ifdef SR_SHIFT_SEND_READBACK_CHECK_EN
        test_readback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
